synthetic_packet_generator: RTL and testbench
=============================================

SYNTHETIC_PACKET_GENERATOR -- requirements
Module: synthetic_packet_generator

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, meaning the word width per channel; legal values are even and in the range 16..32.
REQ-002 SHALL provide parameter NUM_CHANNELS, default 8, meaning the number of replicated RX lanes.
REQ-003 SHALL provide parameter PAYLOAD_LEN, default 125, meaning payload words per packet; legal range is 1..255.
REQ-004 SHALL provide parameter GAP_LEN, default 22, meaning idle words between packets; legal range is 1..255.
REQ-005 SHALL provide parameters HEADER_WORD (default 16'hDEAD), ENDER_WORD (default 16'hBEEF) and TS_INIT (default 10), all zero-extended to DATA_WIDTH.
REQ-006 SHALL provide ports, one per line, as listed in REQ-007 to REQ-017.
REQ-007 clk_trans  input  1  Transceiver-domain clock; the only clock; all logic is on its rising edge.
REQ-008 rst  input  1  Asynchronous, active-high reset.
REQ-009 start  input  1  Run request, level-sensitive.
REQ-010 pause  input  1  Freeze generation while high.
REQ-011 mode  input  2  Payload pattern: 0 = counter, 1 = channel-staggered counter, 2 = PRBS16, 3 = reserved (behaves as 0).
REQ-012 pkt_limit  input  16  Number of packets per run; 0 means unlimited.
REQ-013 rx_parallel_data  output  NUM_CHANNELS*DATA_WIDTH  Flattened lane data; lane c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-014 pkt_valid  output  1  High while the current word is part of a packet (header through ender).
REQ-015 sop / eop  output  1 each  High on the header word / the ender word respectively.
REQ-016 pkt_count  output  16  Number of enders emitted since the last run started; wraps modulo 2^16.
REQ-017 busy / done  output  1 each  busy: state is not IDLE and not DONE. done: state is DONE.

Function
REQ-018 SHALL implement the states IDLE, HEADER, TIMESTAMP, PAYLOAD, ENDER, GAP and DONE; every output is registered.
REQ-019 In each running state, SHALL load the outputs with that state's word at the rising edge and advance the state on the same edge.
REQ-020 In IDLE, SHALL move to HEADER when start=1 and clear pkt_count, the iteration counter and the payload LFSR (to its seed); data outputs are 0.
REQ-021 HEADER SHALL emit HEADER_WORD with sop=1, then go to TIMESTAMP.
REQ-022 TIMESTAMP SHALL emit the timestamp register, then increment it modulo 2^DATA_WIDTH and go to PAYLOAD.
REQ-023 PAYLOAD SHALL emit exactly PAYLOAD_LEN words with word index k = 0..PAYLOAD_LEN-1, then go to ENDER.
REQ-024 In mode 0, the payload word SHALL be {iteration[DATA_WIDTH/2-1:0], k[DATA_WIDTH/2-1:0]}, identical on all lanes.
REQ-025 In mode 1, the payload word on lane c SHALL be the mode-0 word plus c, modulo 2^DATA_WIDTH.
REQ-026 In mode 2, the payload word SHALL be a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1), zero-extended and identical on all lanes; the LFSR advances once per payload word only.
REQ-027 ENDER SHALL emit ENDER_WORD with eop=1, increment the iteration counter (wrapping) and pkt_count, then go to GAP.
REQ-028 GAP SHALL emit 0 with pkt_valid=0 for exactly GAP_LEN cycles.
REQ-029 On leaving GAP, SHALL go to DONE if pkt_limit≠0 and pkt_count≥pkt_limit; else to IDLE if start=0; else to HEADER.
REQ-030 Deasserting start mid-packet SHALL NOT truncate the packet; the current packet and its gap complete first.
REQ-031 DONE SHALL hold all data outputs at 0 with done=1, and return to IDLE only when start=0.
REQ-032 While pause=1 in a running state, SHALL hold the state, all counters and the LFSR, and drive data, pkt_valid, sop and eop to 0; on release, SHALL re-emit the word that was due.
REQ-033 pause SHALL have no effect in IDLE or DONE.
REQ-034 mode SHALL be sampled only at the HEADER state; changes to mode mid-packet SHALL take effect at the next packet.
REQ-035 The timestamp SHALL persist across runs and return to TS_INIT only on reset.

Reset
REQ-036 While rst=1, SHALL force state to IDLE, all data and flag outputs to 0, pkt_count to 0, iteration to 0, timestamp to TS_INIT and the LFSR to its seed, asynchronously.
REQ-037 Reset asserted mid-packet SHALL abort the packet immediately with no ender emitted.

Verification
REQ-038 Defaults, mode 0, start held: the sequence on every lane SHALL be DEAD, 000A, 0000..007C, BEEF, then 22 zeros, then DEAD, 000B, 0100...; sop and eop each pulse once per packet.
REQ-039 Mode 1, NUM_CHANNELS=8: payload word 0 of packet 0 SHALL read 0000 on lane 0 and 0007 on lane 7; the header SHALL be DEAD on all lanes.
REQ-040 pkt_limit=3: after the third BEEF and 22 gap cycles, done=1 and pkt_count=3; with start dropped, the block returns to IDLE; with start re-raised, the next timestamp is 000D.
REQ-041 Pause held for 5 cycles at payload k=10: outputs SHALL be 0 for 5 cycles, then word 0x000A resumes, with total payload count still 125.
REQ-042 start dropped at payload k=50: the packet SHALL complete through BEEF and the gap, then go to IDLE with busy=0.
REQ-043 rst pulsed at payload k=60: outputs SHALL be 0 immediately; after release with start=1, the first timestamp SHALL be 000A.

Source files
------------

// File: rtl/synthetic_packet_generator.sv
// rtl/synthetic_packet_generator.sv - framed synthetic test-pattern source replicated across RX lanes
//
// Purpose:
//   Emits framed packets (header, timestamp, payload, ender) separated by idle
//   gap words, on every RX lane in parallel. Payload words come from a counter,
//   a lane-staggered counter or a PRBS16 sequence. Runs can be unlimited or
//   stop after pkt_limit packets. A pause input freezes generation in place.
//
// Ports:
//   clk_trans         in   transceiver clock, all logic on its rising edge
//   rst               in   asynchronous active-high reset
//   start             in   level-sensitive run request
//   pause             in   freeze generation while high (running states only)
//   mode[1:0]         in   0 counter, 1 lane-staggered counter, 2 PRBS16, 3 as 0
//   pkt_limit[15:0]   in   packets per run, 0 = unlimited
//   rx_parallel_data  out  lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   pkt_valid         out  word belongs to a packet (header through ender)
//   sop / eop         out  header word / ender word
//   pkt_count[15:0]   out  enders emitted since the current run started
//   busy / done       out  generator running / run finished on pkt_limit

module synthetic_packet_generator #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    NUM_CHANNELS = 8,
  parameter int                    PAYLOAD_LEN  = 125,
  parameter int                    GAP_LEN      = 22,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD  = DATA_WIDTH'(16'hDEAD),
  parameter logic [DATA_WIDTH-1:0] ENDER_WORD   = DATA_WIDTH'(16'hBEEF),
  parameter logic [DATA_WIDTH-1:0] TS_INIT      = DATA_WIDTH'(10)
) (
  input  logic                               clk_trans,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               pause,
  input  logic [1:0]                         mode,
  input  logic [15:0]                        pkt_limit,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] rx_parallel_data,
  output logic                               pkt_valid,
  output logic                               sop,
  output logic                               eop,
  output logic [15:0]                        pkt_count,
  output logic                               busy,
  output logic                               done
);

  localparam int          HALF      = DATA_WIDTH / 2;
  localparam logic [7:0]  K_LAST    = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0]  G_LAST    = 8'(GAP_LEN - 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [1:0]  MODE_STAG = 2'd1;
  localparam logic [1:0]  MODE_PRBS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_TIMESTAMP, S_PAYLOAD, S_ENDER, S_GAP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            k_q;
  logic [7:0]            gap_q;
  logic [HALF-1:0]       iter_q;
  logic [DATA_WIDTH-1:0] ts_q;
  logic [15:0]           lfsr_q;
  logic [15:0]           lfsr_next;
  logic [1:0]            mode_q;
  logic                  running;
  logic                  hold;
  logic                  limit_hit;
  logic [DATA_WIDTH-1:0] base_word;

  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_d;
  logic                               valid_d, sop_d, eop_d, busy_d, done_d;

  assign running   = (state_q != S_IDLE) && (state_q != S_DONE);
  // pause only freezes the running states; IDLE and DONE ignore it
  assign hold      = running && pause;
  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  // pkt_count already includes the packet whose gap is ending
  assign limit_hit = (pkt_limit != 16'd0) && (pkt_count >= pkt_limit);
  assign base_word = {iter_q, HALF'(k_q)};

  // State register
  always_ff @(posedge clk_trans or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        S_IDLE:      if (start) state_d = S_HEADER;
        S_HEADER:    state_d = S_TIMESTAMP;
        S_TIMESTAMP: state_d = S_PAYLOAD;
        S_PAYLOAD:   if (k_q == K_LAST) state_d = S_ENDER;
        S_ENDER:     state_d = S_GAP;
        S_GAP: begin
          if (gap_q == G_LAST) begin
            if (limit_hit)   state_d = S_DONE;
            else if (!start) state_d = S_IDLE;
            else             state_d = S_HEADER;
          end
        end
        S_DONE:      if (!start) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    if (!hold) begin
      case (state_q)
        S_HEADER: begin
          valid_d = 1'b1;
          sop_d   = 1'b1;
          for (int c = 0; c < NUM_CHANNELS; c++) data_d[c*DATA_WIDTH +: DATA_WIDTH] = HEADER_WORD;
        end
        S_TIMESTAMP: begin
          valid_d = 1'b1;
          for (int c = 0; c < NUM_CHANNELS; c++) data_d[c*DATA_WIDTH +: DATA_WIDTH] = ts_q;
        end
        S_PAYLOAD: begin
          valid_d = 1'b1;
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (mode_q)
              MODE_STAG: data_d[c*DATA_WIDTH +: DATA_WIDTH] = base_word + DATA_WIDTH'(c);
              MODE_PRBS: data_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(lfsr_q);
              default:   data_d[c*DATA_WIDTH +: DATA_WIDTH] = base_word;
            endcase
          end
        end
        S_ENDER: begin
          valid_d = 1'b1;
          eop_d   = 1'b1;
          for (int c = 0; c < NUM_CHANNELS; c++) data_d[c*DATA_WIDTH +: DATA_WIDTH] = ENDER_WORD;
        end
        default: ;
      endcase
    end
  end

  // Counters, timestamp, LFSR and captured mode; all frozen while held
  always_ff @(posedge clk_trans or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      gap_q     <= '0;
      iter_q    <= '0;
      ts_q      <= TS_INIT;
      lfsr_q    <= LFSR_SEED;
      mode_q    <= '0;
      pkt_count <= '0;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_q       <= '0;
            gap_q     <= '0;
            iter_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            pkt_count <= '0;
          end
        end
        S_HEADER: begin
          // mode is latched once per packet so mid-packet changes wait
          mode_q <= mode;
          k_q    <= '0;
          gap_q  <= '0;
        end
        S_TIMESTAMP: ts_q <= ts_q + DATA_WIDTH'(1);
        S_PAYLOAD: begin
          k_q <= k_q + 8'd1;
          if (mode_q == MODE_PRBS) lfsr_q <= lfsr_next;
        end
        S_ENDER: begin
          iter_q    <= iter_q + HALF'(1);
          pkt_count <= pkt_count + 16'd1;
        end
        S_GAP:   gap_q <= gap_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk_trans or posedge rst) begin
    if (rst) begin
      rx_parallel_data <= '0;
      pkt_valid        <= 1'b0;
      sop              <= 1'b0;
      eop              <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      rx_parallel_data <= data_d;
      pkt_valid        <= valid_d;
      sop              <= sop_d;
      eop              <= eop_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

endmodule

// File: tb/tb_synthetic_packet_generator.sv
// tb/tb_synthetic_packet_generator.sv - bench for synthetic_packet_generator against a packet-level model
module tb_synthetic_packet_generator;

  localparam int DW  = 16;
  localparam int NCH = 8;
  localparam int PL  = 125;
  localparam int GL  = 22;
  localparam int BW  = DW * NCH;

  logic          clk_trans = 1'b0;
  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic          pause     = 1'b0;
  logic [1:0]    mode      = 2'd0;
  logic [15:0]   pkt_limit = 16'd0;
  logic [BW-1:0] rx_parallel_data;
  logic          pkt_valid, sop, eop, busy, done;
  logic [15:0]   pkt_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ts    = 10;
  int m_iter  = 0;
  int m_lfsr  = 'hACE1;
  int m_count = 0;

  always #5 clk_trans = ~clk_trans;

  synthetic_packet_generator dut (
    .clk_trans        (clk_trans),
    .rst              (rst),
    .start            (start),
    .pause            (pause),
    .mode             (mode),
    .pkt_limit        (pkt_limit),
    .rx_parallel_data (rx_parallel_data),
    .pkt_valid        (pkt_valid),
    .sop              (sop),
    .eop              (eop),
    .pkt_count        (pkt_count),
    .busy             (busy),
    .done             (done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_trans);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] flags();
    return BW'({pkt_valid, sop, eop, busy, done});
  endfunction

  function automatic logic [BW-1:0] fexp(input logic v, s, e, b, d);
    return BW'({v, s, e, b, d});
  endfunction

  function automatic logic [BW-1:0] rep(input int w);
    logic [BW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = DW'(w);
    return r;
  endfunction

  function automatic int lfsr_step(input int l);
    int b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  function automatic logic [BW-1:0] pay(input int md, input int k);
    logic [BW-1:0] r;
    for (int c = 0; c < NCH; c++) begin
      int w;
      if (md == 2)      w = m_lfsr;
      else if (md == 1) w = ((m_iter % 256) * 256 + k + c) % 65536;
      else              w = (m_iter % 256) * 256 + k;
      r[c*DW +: DW] = DW'(w);
    end
    return r;
  endfunction

  function automatic int rp(input bit en);
    if (!en) return 0;
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // one output word, optionally preceded by np paused cycles
  task automatic slot(input string tag, input logic [BW-1:0] d,
                      input logic v, s, e, b, dn, input int np);
    for (int i = 0; i < np; i++) begin
      pause = 1'b1;
      tick();
      chk({tag, "_paused_data"}, rx_parallel_data, '0);
      chk({tag, "_paused_flags"}, flags(), fexp(0, 0, 0, 1, 0));
    end
    pause = 1'b0;
    tick();
    chk({tag, "_data"}, rx_parallel_data, d);
    chk({tag, "_flags"}, flags(), fexp(v, s, e, b, dn));
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    chk("run_start_data", rx_parallel_data, '0);
    chk("run_start_flags", flags(), fexp(0, 0, 0, 1, 0));
    chk("run_start_count", BW'(pkt_count), '0);
    m_count = 0;
    m_iter  = 0;
    m_lfsr  = 'hACE1;
  endtask

  task automatic idle_ticks(input int n, input logic dn);
    for (int i = 0; i < n; i++) begin
      pause = 1'($urandom_range(0, 1));
      tick();
      chk("still_data", rx_parallel_data, '0);
      chk("still_flags", flags(), fexp(0, 0, 0, 0, dn));
    end
    pause = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_data", rx_parallel_data, '0);
    chk("async_rst_flags", flags(), fexp(0, 0, 0, 0, 0));
    chk("async_rst_count", BW'(pkt_count), '0);
    tick();
    chk("rst_held_data", rx_parallel_data, '0);
    rst     = 1'b0;
    m_ts    = 10;
    m_count = 0;
    m_iter  = 0;
    m_lfsr  = 'hACE1;
  endtask

  // rnd: random pauses; pk/plen: forced pause at payload k; dk: drop start at k;
  // rk: reset at k (packet aborted); mut: scramble mode mid-packet
  task automatic do_packet(input bit rnd, input int pk, input int plen,
                           input int dk, input int rk, input bit mut);
    int md;
    logic nb, nd;
    md = int'(mode);
    if (md == 3) md = 0;
    slot("header", rep('hDEAD), 1, 1, 0, 1, 0, rp(rnd));
    slot("timestamp", rep(m_ts), 1, 0, 0, 1, 0, rp(rnd));
    m_ts = (m_ts + 1) % 65536;
    for (int k = 0; k < PL; k++) begin
      int np;
      np = (k == pk) ? plen : rp(rnd);
      if (mut && k == 20) mode = 2'($urandom_range(0, 3));
      if (k == dk) start = 1'b0;
      if (k == rk) begin
        do_reset();
        return;
      end
      slot("payload", pay(md, k), 1, 0, 0, 1, 0, np);
      if (md == 2) m_lfsr = lfsr_step(m_lfsr);
    end
    slot("ender", rep('hBEEF), 1, 0, 1, 1, 0, rp(rnd));
    m_count++;
    m_iter++;
    chk("pkt_count", BW'(pkt_count), BW'(m_count % 65536));
    for (int g = 0; g < GL; g++) begin
      nb = 1'b1;
      nd = 1'b0;
      if (g == GL - 1) begin
        if (pkt_limit != 0 && m_count >= int'(pkt_limit)) begin
          nb = 1'b0;
          nd = 1'b1;
        end else if (!start) begin
          nb = 1'b0;
        end
      end
      slot("gap", '0, 0, 0, 0, nb, nd, rp(rnd));
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk_trans);
    #1;
    chk("reset_data", rx_parallel_data, '0);
    chk("reset_flags", flags(), fexp(0, 0, 0, 0, 0));
    chk("reset_count", BW'(pkt_count), '0);
    rst = 1'b0;
    idle_ticks(3, 1'b0);

    // run A: unlimited
    mode = 2'd0;
    pkt_limit = 16'd0;
    begin_run();
    do_packet(0, -1, 0, -1, -1, 0);
    do_packet(0, -1, 0, -1, -1, 0);
    mode = 2'd1;
    do_packet(0, -1, 0, -1, -1, 0);
    mode = 2'd0;
    do_packet(0, 10, 5, -1, -1, 0);
    for (int i = 0; i < 3; i++) begin
      mode = 2'($urandom_range(0, 3));
      do_packet(1, -1, 0, -1, -1, 1);
    end
    mode = 2'd2;
    do_packet(1, -1, 0, -1, -1, 0);
    do_packet(1, -1, 0, 50, -1, 0);
    idle_ticks(4, 1'b0);

    // run B: limited to three packets
    pkt_limit = 16'd3;
    mode = 2'd1;
    begin_run();
    do_packet(0, -1, 0, -1, -1, 0);
    mode = 2'd2;
    do_packet(1, -1, 0, -1, -1, 0);
    do_packet(1, -1, 0, -1, -1, 1);
    chk("done_count", BW'(pkt_count), BW'(m_count));
    idle_ticks(4, 1'b1);
    start = 1'b0;
    tick();
    chk("done_exit_flags", flags(), fexp(0, 0, 0, 0, 0));

    // run C: reset mid-payload, then a clean run dropped mid-packet
    pkt_limit = 16'd0;
    mode = 2'd0;
    begin_run();
    do_packet(0, -1, 0, -1, 60, 0);
    begin_run();
    do_packet(1, -1, 0, 30, -1, 0);
    idle_ticks(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
